// File: rtl/taxi_eth_port_led.sv
// taxi_eth_port_led
//   Per-port front-panel LED controller. Debounces per-lane link status and
//   classifies each port as absent / down / partial / up. Stretches lane
//   activity pulses into a visible on/off blink. Adds a global locate blink
//   and a lamp-test / all-off override.
//
// Ports
//   clk_i              clock, all logic on the rising edge
//   rst_n_i            synchronous active-low reset
//   lane_rx_status_i   raw lane link status (lane l of port p = p*LANE_CNT+l)
//   lane_act_i         single-cycle lane activity pulses
//   port_present_i     module present per port
//   cfg_mode_i         0 normal, 1 lamp test, 2 all off, 3 normal
//   cfg_locate_i       per-port locate (blue blink) enable
//   port_link_up_o     debounced all-lanes-up flag, unaffected by cfg_mode_i
//   port_led_*_o       registered LED drives, active high
module taxi_eth_port_led #(
  parameter int unsigned PORT_CNT    = 2,
  parameter int unsigned LANE_CNT    = 4,
  parameter int unsigned TICK_DIV    = 125000,
  parameter int unsigned LINK_DEB    = 8,
  parameter int unsigned ACT_STRETCH = 50,
  parameter int unsigned BLINK_HALF  = 250
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [PORT_CNT*LANE_CNT-1:0] lane_rx_status_i,
  input  logic [PORT_CNT*LANE_CNT-1:0] lane_act_i,
  input  logic [PORT_CNT-1:0]          port_present_i,
  input  logic [1:0]                   cfg_mode_i,
  input  logic [PORT_CNT-1:0]          cfg_locate_i,
  output logic [PORT_CNT-1:0]          port_link_up_o,
  output logic [PORT_CNT-1:0]          port_led_act_o,
  output logic [PORT_CNT-1:0]          port_led_stat_r_o,
  output logic [PORT_CNT-1:0]          port_led_stat_g_o,
  output logic [PORT_CNT-1:0]          port_led_stat_b_o,
  output logic [PORT_CNT-1:0]          port_led_stat_y_o
);

  localparam int unsigned NL = PORT_CNT * LANE_CNT;
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int unsigned DW = $clog2(LINK_DEB + 1);
  localparam int unsigned AW = $clog2(ACT_STRETCH + 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ON       = 2'd1;
  localparam logic [1:0] ST_OFF_HOLD = 2'd2;

  localparam logic [1:0] MODE_LAMP = 2'd1;
  localparam logic [1:0] MODE_OFF  = 2'd2;

  // Tick prescaler and locate blink
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;

  // Lane debounce
  logic [NL-1:0] deb_q, deb_d;
  logic [DW-1:0] dcnt_q [NL];
  logic [DW-1:0] dcnt_d [NL];

  // Activity stretchers
  logic [1:0]          st_q     [PORT_CNT];
  logic [1:0]          st_d     [PORT_CNT];
  logic [AW-1:0]       act_cnt_q[PORT_CNT];
  logic [AW-1:0]       act_cnt_d[PORT_CNT];
  logic [PORT_CNT-1:0] pend_q, pend_d;

  // Output registers
  logic [PORT_CNT-1:0] link_q, act_q, r_q, g_q, b_q, y_q;
  logic [PORT_CNT-1:0] link_d, act_d, r_d, g_d, b_d, y_d;

  always_comb begin
    tick        = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (tick) begin
      if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  always_comb begin
    deb_d  = deb_q;
    dcnt_d = dcnt_q;
    for (int unsigned i = 0; i < NL; i++) begin
      if (!port_present_i[i / LANE_CNT]) begin
        deb_d[i]  = 1'b0;
        dcnt_d[i] = '0;
      end else if (tick) begin
        if (lane_rx_status_i[i] == deb_q[i]) begin
          dcnt_d[i] = '0;
        end else if (dcnt_q[i] == DW'(LINK_DEB - 1)) begin
          // this tick is the LINK_DEB-th consecutive disagreement
          deb_d[i]  = ~deb_q[i];
          dcnt_d[i] = '0;
        end else begin
          dcnt_d[i] = dcnt_q[i] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    st_d      = st_q;
    act_cnt_d = act_cnt_q;
    pend_d    = pend_q;
    for (int unsigned p = 0; p < PORT_CNT; p++) begin
      logic act_any;
      logic pend_n;
      act_any = |lane_act_i[p*LANE_CNT +: LANE_CNT];
      pend_n  = pend_q[p] | act_any;
      if (!port_present_i[p]) begin
        st_d[p]      = ST_IDLE;
        act_cnt_d[p] = '0;
        pend_d[p]    = 1'b0;
      end else begin
        case (st_q[p])
          ST_ON: begin
            pend_d[p] = pend_n;
            if (tick) begin
              if (act_cnt_q[p] <= AW'(1)) begin
                st_d[p]      = ST_OFF_HOLD;
                act_cnt_d[p] = AW'(ACT_STRETCH);
              end else begin
                act_cnt_d[p] = act_cnt_q[p] - AW'(1);
              end
            end
          end
          ST_OFF_HOLD: begin
            pend_d[p] = pend_n;
            if (tick) begin
              if (act_cnt_q[p] <= AW'(1)) begin
                // a pulse arriving on the expiry cycle itself still counts
                st_d[p]      = pend_n ? ST_ON : ST_IDLE;
                act_cnt_d[p] = pend_n ? AW'(ACT_STRETCH) : '0;
                pend_d[p]    = 1'b0;
              end else begin
                act_cnt_d[p] = act_cnt_q[p] - AW'(1);
              end
            end
          end
          default: begin
            pend_d[p] = 1'b0;
            if (act_any) begin
              st_d[p]      = ST_ON;
              act_cnt_d[p] = AW'(ACT_STRETCH);
            end else begin
              st_d[p] = ST_IDLE;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    link_d = '0;
    act_d  = '0;
    r_d    = '0;
    g_d    = '0;
    b_d    = '0;
    y_d    = '0;
    for (int unsigned p = 0; p < PORT_CNT; p++) begin
      logic pres;
      logic all_up;
      logic any_up;
      pres   = port_present_i[p];
      all_up = &deb_q[p*LANE_CNT +: LANE_CNT];
      any_up = |deb_q[p*LANE_CNT +: LANE_CNT];
      link_d[p] = pres & all_up;
      r_d[p]    = pres & ~any_up;
      y_d[p]    = pres & any_up & ~all_up;
      g_d[p]    = pres & all_up;
      b_d[p]    = cfg_locate_i[p] & blink_q;
      act_d[p]  = (st_q[p] == ST_ON);
    end
    // link flag is deliberately left out of the override
    case (cfg_mode_i)
      MODE_LAMP: begin
        act_d = '1;
        r_d   = '1;
        g_d   = '1;
        b_d   = '1;
        y_d   = '1;
      end
      MODE_OFF: begin
        act_d = '0;
        r_d   = '0;
        g_d   = '0;
        b_d   = '0;
        y_d   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tick_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      deb_q       <= '0;
      for (int unsigned i = 0; i < NL; i++) dcnt_q[i] <= '0;
      for (int unsigned p = 0; p < PORT_CNT; p++) begin
        st_q[p]      <= ST_IDLE;
        act_cnt_q[p] <= '0;
      end
      pend_q <= '0;
      link_q <= '0;
      act_q  <= '0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      y_q    <= '0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      deb_q       <= deb_d;
      dcnt_q      <= dcnt_d;
      st_q        <= st_d;
      act_cnt_q   <= act_cnt_d;
      pend_q      <= pend_d;
      link_q      <= link_d;
      act_q       <= act_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      y_q         <= y_d;
    end
  end

  assign port_link_up_o    = link_q;
  assign port_led_act_o    = act_q;
  assign port_led_stat_r_o = r_q;
  assign port_led_stat_g_o = g_q;
  assign port_led_stat_b_o = b_q;
  assign port_led_stat_y_o = y_q;

endmodule
